mdu_core: RTL and testbench

Parametrised multi-cycle multiply/divide unit for the pipeline's EX stage. It sits beside the combinational ALU and holds the architectural HI/LO registers. It handles signed and unsigned multiply and divide, as well as HI/LO moves. Multiply and divide complete after a configurable number of cycles, and a busy flag tells the hazard unit to stall the EX stage while an operation is in flight.

---
 rtl/mdu_core.sv | 140 ++++++++++++++
 tb/tb_mdu_core.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_core.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Results are computed at issue and retired after a fixed latency so the hazard unit sees a deterministic stall.
module mdu_core #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] md_A,
  input  logic [WIDTH-1:0] md_B,
  input  logic [2:0]       MDUCtrl,
  input  logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_pend_hi, r_pend_lo, r_hi, r_lo;
  logic             r_pend_wr;
  logic             w_ld_pend, w_wb, w_mthi, w_mtlo;

  logic signed [WIDTH-1:0]   w_a_s, w_b_div_s, w_q_s, w_r_s;
  logic        [WIDTH-1:0]   w_b_nz, w_q_u, w_r_u;
  logic        [2*WIDTH-1:0] w_a_ext, w_b_ext, w_prod;
  logic                      w_b_zero, w_div_ovf;
  logic        [WIDTH-1:0]   w_res_hi, w_res_lo;
  logic                      w_res_wr;

  assign w_a_s     = $signed(md_A);
  assign w_b_zero  = (md_B == '0);
  assign w_div_ovf = (md_A == {1'b1, {(WIDTH-1){1'b0}}}) && (md_B == '1);
  assign w_b_nz    = w_b_zero ? WIDTH'(1) : md_B;
  // Dividing MIN by 1 instead of -1 yields exactly the defined overflow result (MIN, remainder 0).
  assign w_b_div_s = (w_b_zero || w_div_ovf) ? WIDTH'(1) : $signed(md_B);
  assign w_q_s     = w_a_s / w_b_div_s;
  assign w_r_s     = w_a_s % w_b_div_s;
  assign w_q_u     = md_A / w_b_nz;
  assign w_r_u     = md_A % w_b_nz;

  assign w_a_ext = (MDUCtrl == 3'd1) ? {{WIDTH{md_A[WIDTH-1]}}, md_A} : {{WIDTH{1'b0}}, md_A};
  assign w_b_ext = (MDUCtrl == 3'd1) ? {{WIDTH{md_B[WIDTH-1]}}, md_B} : {{WIDTH{1'b0}}, md_B};
  assign w_prod  = w_a_ext * w_b_ext;

  always_comb begin
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    w_res_wr = 1'b1;
    case (MDUCtrl)
      3'd3: begin
        w_res_hi = w_r_s;
        w_res_lo = w_q_s;
        w_res_wr = !w_b_zero;
      end
      3'd4: begin
        w_res_hi = w_r_u;
        w_res_lo = w_q_u;
        w_res_wr = !w_b_zero;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ld_pend   = 1'b0;
    w_wb        = 1'b0;
    w_mthi      = 1'b0;
    w_mtlo      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          case (MDUCtrl)
            3'd1, 3'd2: begin
              w_state_nxt = RUN;
              w_cnt_nxt   = CW'(MULT_CYCLES);
              w_ld_pend   = 1'b1;
            end
            3'd3, 3'd4: begin
              w_state_nxt = RUN;
              w_cnt_nxt   = CW'(DIV_CYCLES);
              w_ld_pend   = 1'b1;
            end
            3'd5:    w_mthi = 1'b1;
            3'd6:    w_mtlo = 1'b1;
            default: ;
          endcase
        end
      end
      RUN: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt = IDLE;
          w_wb        = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_wr <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_ld_pend) begin
        r_pend_hi <= w_res_hi;
        r_pend_lo <= w_res_lo;
        r_pend_wr <= w_res_wr;
      end
      // Divide by zero still occupies the unit but leaves HI/LO untouched.
      if (w_wb && r_pend_wr) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
      if (w_mthi) r_hi <= md_A;
      if (w_mtlo) r_lo <= md_A;
    end
  end

  assign busy   = (r_state == RUN);
  assign hi_out = r_hi;
  assign lo_out = r_lo;

endmodule

// File: tb/tb_mdu_core.sv
// Scoreboard bench for mdu_core: instance 0 uses 5/10-cycle latency, instance 1 uses 1/1.
// Expected HI/LO/busy-length entries are queued at issue and checked when busy falls.
module tb_mdu_core;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [W-1:0] a [2];
  logic [W-1:0] b [2];
  logic [2:0]   op [2];
  logic         st [2];
  logic         busy_w [2];
  logic [W-1:0] hi_w [2];
  logic [W-1:0] lo_w [2];

  mdu_core #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut0 (
    .clk(clk), .reset(rst_n), .md_A(a[0]), .md_B(b[0]), .MDUCtrl(op[0]),
    .start(st[0]), .busy(busy_w[0]), .hi_out(hi_w[0]), .lo_out(lo_w[0])
  );

  mdu_core #(.WIDTH(W), .MULT_CYCLES(1), .DIV_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(rst_n), .md_A(a[1]), .md_B(b[1]), .MDUCtrl(op[1]),
    .start(st[1]), .busy(busy_w[1]), .hi_out(hi_w[1]), .lo_out(lo_w[1])
  );

  typedef struct {
    int           inst;
    int           id;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           len;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input int id, input logic [W-1:0] got, input logic [W-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s vec%0d: got %h want %h", nm, id, got, want);
    end
  endtask

  // Monitor: a busy fall outside reset is a completion; pop and compare.
  logic prev_b [2];
  int   run_len [2];
  initial begin
    prev_b[0] = 1'b0; prev_b[1] = 1'b0;
    run_len[0] = 0;   run_len[1] = 0;
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        run_len[k] = 0;
      end else if (busy_w[k]) begin
        run_len[k]++;
      end else if (prev_b[k]) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL completion inst%0d: got unexpected write-back want none", k);
        end else begin
          e = sb.pop_front();
          chk("inst", e.id, W'(k), W'(e.inst));
          chk("hi", e.id, hi_w[k], e.hi);
          chk("lo", e.id, lo_w[k], e.lo);
          chk("busy_len", e.id, W'(run_len[k]), W'(e.len));
        end
        run_len[k] = 0;
      end
      prev_b[k] = busy_w[k];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input int id, input logic [W-1:0] hi, input logic [W-1:0] lo, input int len);
    exp_t e;
    e.inst = k; e.id = id; e.hi = hi; e.lo = lo; e.len = len;
    sb.push_back(e);
  endtask

  // Operands are scrambled after the start edge; results must not follow them.
  task automatic issue(input int k, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    a[k] = x; b[k] = y; op[k] = o; st[k] = 1'b1;
    tick();
    st[k] = 1'b0; op[k] = 3'd0; a[k] = $urandom; b[k] = $urandom;
  endtask

  task automatic wait_idle(input int k, input int id);
    int n;
    n = 0;
    while (busy_w[k] && n < 200) begin
      tick();
      n++;
    end
    if (busy_w[k]) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout vec%0d: got busy after %0d cycles want idle", id, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      a[k] = '0; b[k] = '0; op[k] = 3'd0; st[k] = 1'b0;
    end
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", 0, W'(busy_w[k]), W'(0));
      chk("rst_hi", 0, hi_w[k], 32'h0);
      chk("rst_lo", 0, lo_w[k], 32'h0);
    end
    rst_n = 1'b1;
    tick();

    push(0, 1, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);  issue(0, 3'd1, 32'hFFFFFFFE, 32'h3); wait_idle(0, 1);
    push(0, 2, 32'hFFFFFFFE, 32'h00000001, 5);  issue(0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF); wait_idle(0, 2);
    push(0, 3, 32'hFFFFFFFF, 32'hFFFFFFFD, 10); issue(0, 3'd3, 32'hFFFFFFF9, 32'h2); wait_idle(0, 3);
    push(0, 4, 32'h1, 32'h3, 10);               issue(0, 3'd4, 32'h7, 32'h2); wait_idle(0, 4);
    push(0, 5, 32'h0, 32'h80000000, 10);        issue(0, 3'd3, 32'h80000000, 32'hFFFFFFFF); wait_idle(0, 5);
    push(0, 6, 32'h40000000, 32'h0, 5);         issue(0, 3'd1, 32'h80000000, 32'h80000000); wait_idle(0, 6);
    push(0, 7, 32'h1, 32'h0, 5);                issue(0, 3'd2, 32'h80000000, 32'h2); wait_idle(0, 7);
    push(0, 8, 32'h1, 32'hFFFFFFFD, 10);        issue(0, 3'd3, 32'h7, 32'hFFFFFFFE); wait_idle(0, 8);
    push(0, 9, 32'hF, 32'h0FFFFFFF, 10);        issue(0, 3'd4, 32'hFFFFFFFF, 32'h10); wait_idle(0, 9);

    issue(0, 3'd5, 32'h11, 32'h0);
    chk("mthi_hi", 10, hi_w[0], 32'h11);
    chk("mthi_busy", 10, W'(busy_w[0]), W'(0));
    issue(0, 3'd6, 32'h22, 32'h0);
    chk("mtlo_lo", 11, lo_w[0], 32'h22);
    chk("mtlo_hi", 11, hi_w[0], 32'h11);
    issue(0, 3'd7, 32'h99, 32'h99);
    chk("rsvd_busy", 12, W'(busy_w[0]), W'(0));
    push(0, 13, 32'h11, 32'h22, 10); issue(0, 3'd3, 32'h5, 32'h0); wait_idle(0, 13);
    push(0, 14, 32'h11, 32'h22, 10); issue(0, 3'd4, 32'h9, 32'h0); wait_idle(0, 14);

    push(0, 15, 32'h0, 32'hC, 5);
    issue(0, 3'd1, 32'h3, 32'h4);
    tick();
    issue(0, 3'd5, 32'hDEAD, 32'h0);
    chk("ilk_busy", 15, W'(busy_w[0]), W'(1));
    chk("ilk_hi", 15, hi_w[0], 32'h11);
    wait_idle(0, 15);
    push(0, 16, 32'h2, 32'hE, 10);
    issue(0, 3'd4, 32'd100, 32'd7);
    chk("b2b_busy", 16, W'(busy_w[0]), W'(1));
    wait_idle(0, 16);

    issue(0, 3'd1, 32'h5, 32'h6);
    tick();
    rst_n = 1'b0;
    #1;
    chk("amid_busy", 17, W'(busy_w[0]), W'(0));
    chk("amid_hi", 17, hi_w[0], 32'h0);
    chk("amid_lo", 17, lo_w[0], 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("post_busy", 17, W'(busy_w[0]), W'(0));
    chk("post_hi", 17, hi_w[0], 32'h0);
    chk("post_lo", 17, lo_w[0], 32'h0);

    push(1, 20, 32'h0, 32'h2A, 1);
    issue(1, 3'd1, 32'h6, 32'h7);
    wait_idle(1, 20);
    push(1, 21, 32'hFFFFFFFE, 32'hFFFFFFFE, 1);
    issue(1, 3'd3, 32'hFFFFFFF8, 32'h3);
    chk("b2b1_busy", 21, W'(busy_w[1]), W'(1));
    wait_idle(1, 21);

    repeat (3) tick();
    chk("sb_left", 99, W'(sb.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
